// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// Holds the FSM state encoding, index width and the round-robin winner search.
package rr_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // First set request bit scanning upward from last_idx+1 with wrap.
    // The 2-bit add wraps naturally, so i==NUM_REQ revisits last_idx last.
    function automatic logic [IDX_W-1:0] next_rr_idx(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   last_idx
    );
        logic [IDX_W-1:0] cand;
        logic             found;
        next_rr_idx = '0;
        found       = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_idx + IDX_W'(i);
            if (!found && req[cand]) begin
                next_rr_idx = cand;
                found       = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/dec2to4_en.sv
// Combinational 2-to-4 decoder with enable; drives the shared one-hot select lines.
module dec2to4_en
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               en,
    output logic [NUM_REQ-1:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_line
            assign onehot[gi] = en && (idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 4 requesters sharing one enable-decoded resource.
// Optional forced release after MAX_HOLD grant cycles: define RR_HOLD_TIMEOUT_EN.
module rr_decode_arbiter
    import rr_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic               timeout
);

    generate
        if (MAX_HOLD < 2 || MAX_HOLD > 31 || (1 << CNT_W) <= MAX_HOLD) begin : g_bad_cfg
            $error("rr_decode_arbiter: MAX_HOLD must be 2..31 and below 2**CNT_W");
        end
    endgenerate

    arb_state_t       state_reg;
    logic [IDX_W-1:0] grant_idx_reg;
    logic [IDX_W-1:0] last_idx_reg;
    logic             en_reg;
    logic [CNT_W-1:0] hold_cnt_reg;

    // grant is a pure decode of registered index/enable, so it clears with reset.
    dec2to4_en u_dec (
        .idx    (grant_idx_reg),
        .en     (en_reg),
        .onehot (grant)
    );

`ifdef RR_HOLD_TIMEOUT_EN
    logic timeout_reg;
    logic others_pending;
    logic hold_at_limit;

    assign others_pending = |(req & ~grant);
    assign hold_at_limit  = (hold_cnt_reg == CNT_W'(MAX_HOLD - 1));
    assign timeout        = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_idx_reg <= '0;
            last_idx_reg  <= IDX_W'(NUM_REQ - 1);
            en_reg        <= 1'b0;
            hold_cnt_reg  <= '0;
`ifdef RR_HOLD_TIMEOUT_EN
            timeout_reg   <= 1'b0;
`endif
        end else begin
`ifdef RR_HOLD_TIMEOUT_EN
            timeout_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE, RELEASE: begin
                    hold_cnt_reg <= '0;
                    if (|req) begin
                        grant_idx_reg <= next_rr_idx(req, last_idx_reg);
                        en_reg        <= 1'b1;
                        state_reg     <= GRANT;
                    end else begin
                        en_reg    <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                GRANT: begin
                    if (!req[grant_idx_reg]) begin
                        en_reg       <= 1'b0;
                        hold_cnt_reg <= '0;
                        last_idx_reg <= grant_idx_reg;
                        state_reg    <= RELEASE;
                    end
`ifdef RR_HOLD_TIMEOUT_EN
                    else if (hold_at_limit && others_pending) begin
                        // Preempted owner becomes lowest priority for the next scan.
                        en_reg       <= 1'b0;
                        hold_cnt_reg <= '0;
                        last_idx_reg <= grant_idx_reg;
                        timeout_reg  <= 1'b1;
                        state_reg    <= RELEASE;
                    end
`endif
                    else if (hold_cnt_reg != {CNT_W{1'b1}}) begin
                        hold_cnt_reg <= hold_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    en_reg       <= 1'b0;
                    hold_cnt_reg <= '0;
                    state_reg    <= IDLE;
                end
            endcase
        end
    end

    assign grant_valid = |grant;
    assign grant_idx   = grant_idx_reg;
    assign hold_cnt    = hold_cnt_reg;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Scoreboard bench for rr_decode_arbiter: directed scenarios plus random requests
// checked against an ownership-level reference model.
module tb_rr_decode_arbiter;

    localparam int TB_MAX_HOLD = 4;
    localparam int TB_CNT_W    = 5;
    localparam int CNT_MAX     = (1 << TB_CNT_W) - 1;

    logic                clk;
    logic                rst_n;
    logic [3:0]          req;
    logic [3:0]          grant;
    logic                grant_valid;
    logic [1:0]          grant_idx;
    logic [TB_CNT_W-1:0] hold_cnt;
    logic                timeout;

    rr_decode_arbiter #(
        .MAX_HOLD (TB_MAX_HOLD),
        .CNT_W    (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .hold_cnt    (hold_cnt),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] idx;
        logic [4:0] hc;
        logic       t;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model: who owns the resource, for how long, and who went last.
    int   m_owner;
    int   m_cnt;
    int   m_last;
    int   m_idx;
    bit   m_tmo;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task model_reset();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 3;
        m_idx   = 0;
        m_tmo   = 0;
    endtask

    task model_step(input logic [3:0] r);
        bit found;
        if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
                m_tmo   = 0;
            end
`ifdef RR_HOLD_TIMEOUT_EN
            else if (m_cnt == TB_MAX_HOLD - 1 && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
                m_tmo   = 1;
            end
`endif
            else begin
                if (m_cnt < CNT_MAX) m_cnt++;
                m_tmo = 0;
            end
        end else begin
            m_tmo = 0;
            m_cnt = 0;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_last + k) % 4]) begin
                    m_owner = (m_last + k) % 4;
                    m_idx   = m_owner;
                    found   = 1;
                end
            end
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.g   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        e.idx = 2'(m_idx);
        e.hc  = 5'(m_cnt);
        e.t   = m_tmo;
        return e;
    endfunction

    // One clock of stimulus: drive at the falling edge, predict the post-edge outputs.
    task cycle(input logic [3:0] r);
        @(negedge clk);
        req = r;
        model_step(r);
        q.push_back(model_out());
    endtask

    // Monitor: compares every registered output one step after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && q.size() > 0) begin
                e = q.pop_front();
                n_txn++;
                $display("txn %0d: req=%b grant=%b idx=%0d hold=%0d tmo=%b (exp grant=%b idx=%0d hold=%0d tmo=%b)",
                         n_txn, req, grant, grant_idx, hold_cnt, timeout, e.g, e.idx, e.hc, e.t);
                check("grant", int'(grant), int'(e.g));
                check("grant_valid", int'(grant_valid), int'(e.g != 4'b0000));
                check("grant_idx", int'(grant_idx), int'(e.idx));
                check("hold_cnt", int'(hold_cnt), int'(e.hc));
                check("timeout", int'(timeout), int'(e.t));
                check("onehot0", int'($onehot0(grant)), 1);
            end
        end
    end

    initial begin
        logic [3:0] r;
        rst_n = 1'b0;
        req   = 4'b0000;
        model_reset();
        #12;
        check("rst_grant", int'(grant), 0);
        check("rst_valid", int'(grant_valid), 0);
        check("rst_idx", int'(grant_idx), 0);
        check("rst_hold", int'(hold_cnt), 0);
        check("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester held 5 cycles, then dropped.
        repeat (5) cycle(4'b0100);
        repeat (2) cycle(4'b0000);

        // All requesting; each owner drops after 3 grant cycles, then re-raises.
        for (int i = 0; i < 20; i++) begin
            r = 4'b1111;
            if (m_owner >= 0 && m_cnt >= 2) r[m_owner] = 1'b0;
            cycle(r);
        end
        repeat (2) cycle(4'b0000);

        // Owner 3 releases while 0 and 1 request: scan wraps to 0.
        repeat (2) cycle(4'b1000);
        repeat (3) cycle(4'b0011);
        repeat (2) cycle(4'b0000);

        // Asynchronous reset in the middle of a grant to requester 1.
        repeat (3) cycle(4'b0010);
        @(posedge clk);
        #3;
        check("pre_rst_grant", int'(grant), 2);
        rst_n = 1'b0;
        req   = 4'b0000;
        #1;
        check("async_rst_grant", int'(grant), 0);
        check("async_rst_valid", int'(grant_valid), 0);
        check("async_rst_hold", int'(hold_cnt), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        // Two contenders held: forced hand-off only when the timeout is compiled in.
        repeat (40) cycle(4'b0011);
        repeat (2) cycle(4'b0000);

        // Random traffic; the current owner usually keeps its request up.
        for (int i = 0; i < 300; i++) begin
            r = 4'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 7) != 0) r[m_owner] = 1'b1;
            cycle(r);
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        #3;
        check("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
